entrada_cofre: RTL and testbench

Sequential front end of the safe (cofre). Captures the user's stored password and each attempt from the 4 switches using two push-buttons, and drives the senha/tentativa pair into the combinational comparator. It samples the comparator's "igual" result, opens the safe, counts failed attempts and enforces a timed lockout. It sits between the board switches/buttons and the comparator/display datapath.

---
 rtl/cofre_pkg.sv | 16 +
 rtl/sincroniza_botao.sv | 30 +++
 rtl/entrada_cofre.sv | 127 ++++++++++++
 tb/tb_entrada_cofre.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cofre_pkg.sv
// Shared types and constants for the safe front end: FSM states, password width
// and the default number of wrong attempts before lockout.
package cofre_pkg;

  localparam int SENHA_W               = 4;
  localparam int MAX_TENTATIVAS_PADRAO = 3;

  typedef enum logic [2:0] {
    SEM_SENHA,
    ARMADO,
    AVALIANDO,
    ABERTO,
    BLOQUEADO
  } estado_t;

endpackage

// File: rtl/sincroniza_botao.sv
// Two-flop synchronizer for an asynchronous push-button followed by a rising-edge
// detector; a press held for any length yields a single one-cycle pulse.
module sincroniza_botao (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulso
);

  logic meta_q;
  logic sinc_q;
  logic ant_q;

  // NOTE: non-blocking assignments keep these three flops a real shift chain;
  // blocking ones would let btn_in ripple straight through in a single edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
      ant_q  <= 1'b0;
    end else begin
      meta_q <= btn_in;
      sinc_q <= meta_q;
      ant_q  <= sinc_q;
    end
  end

  assign pulso = sinc_q & ~ant_q;

endmodule

// File: rtl/entrada_cofre.sv
// Safe front end: captures password and attempts from the switches, samples the
// external comparator, opens the safe, counts failures and enforces a timed lockout.
module entrada_cofre
  import cofre_pkg::*;
#(
  parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO,
  parameter int TEMPO_BLOQUEIO = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SENHA_W-1:0] chaves,
  input  logic               btn_gravar,
  input  logic               btn_testar,
  input  logic               igual,
  output logic [SENHA_W-1:0] senha,
  output logic [SENHA_W-1:0] tentativa,
  output logic               tentativa_valida,
  output logic               aberto,
  output logic               bloqueado,
  output logic [2:0]         restantes
);

  localparam int                 TIMER_W       = $clog2(TEMPO_BLOQUEIO);
  localparam logic [2:0]         RESTANTES_MAX = 3'(MAX_TENTATIVAS);
  localparam logic [TIMER_W-1:0] TIMER_CARGA   = TIMER_W'(TEMPO_BLOQUEIO - 1);
  localparam logic [TIMER_W-1:0] TIMER_UM      = TIMER_W'(1);

  logic pulso_gravar;
  logic pulso_testar;

  sincroniza_botao u_sinc_gravar (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_gravar),
    .pulso  (pulso_gravar)
  );

  sincroniza_botao u_sinc_testar (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_testar),
    .pulso  (pulso_testar)
  );

  estado_t            state_q;
  logic [SENHA_W-1:0] senha_q;
  logic [SENHA_W-1:0] tentativa_q;
  logic               tentativa_valida_q;
  logic               aberto_q;
  logic               bloqueado_q;
  logic [2:0]         restantes_q;
  logic [TIMER_W-1:0] timer_q;

  // NOTE: the state-decoded flags are written on the same edge that changes
  // state_q, so they come straight from flops with no decode logic behind them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= SEM_SENHA;
      senha_q            <= '0;
      tentativa_q        <= '0;
      tentativa_valida_q <= 1'b0;
      aberto_q           <= 1'b0;
      bloqueado_q        <= 1'b0;
      restantes_q        <= RESTANTES_MAX;
      timer_q            <= '0;
    end else begin
      tentativa_valida_q <= 1'b0;
      case (state_q)
        SEM_SENHA: begin
          if (pulso_gravar) begin
            senha_q <= chaves;
            state_q <= ARMADO;
          end
        end
        ARMADO: begin
          if (pulso_testar) begin
            tentativa_q        <= chaves;
            tentativa_valida_q <= 1'b1;
            state_q            <= AVALIANDO;
          end
        end
        AVALIANDO: begin
          if (igual) begin
            aberto_q    <= 1'b1;
            restantes_q <= RESTANTES_MAX;
            state_q     <= ABERTO;
          end else if (restantes_q > 3'd1) begin
            restantes_q <= restantes_q - 3'd1;
            state_q     <= ARMADO;
          end else begin
            restantes_q <= 3'd0;
            timer_q     <= TIMER_CARGA;
            bloqueado_q <= 1'b1;
            state_q     <= BLOQUEADO;
          end
        end
        ABERTO: begin
          // Gravar wins over a coincident testar so an edit is never lost.
          if (pulso_gravar) begin
            senha_q <= chaves;
          end else if (pulso_testar) begin
            aberto_q <= 1'b0;
            state_q  <= ARMADO;
          end
        end
        BLOQUEADO: begin
          if (timer_q == '0) begin
            bloqueado_q <= 1'b0;
            restantes_q <= RESTANTES_MAX;
            state_q     <= ARMADO;
          end else begin
            timer_q <= timer_q - TIMER_UM;
          end
        end
        default: state_q <= SEM_SENHA;
      endcase
    end
  end

  assign senha            = senha_q;
  assign tentativa        = tentativa_q;
  assign tentativa_valida = tentativa_valida_q;
  assign aberto           = aberto_q;
  assign bloqueado        = bloqueado_q;
  assign restantes        = restantes_q;

endmodule

// File: tb/tb_entrada_cofre.sv
// Self-checking bench for entrada_cofre: a flag-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_entrada_cofre;

  localparam int MAX_T = 3;
  localparam int TEMPO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chaves;
  logic       btn_gravar;
  logic       btn_testar;
  logic       igual;
  logic [3:0] senha;
  logic [3:0] tentativa;
  logic       tentativa_valida;
  logic       aberto;
  logic       bloqueado;
  logic [2:0] restantes;

  entrada_cofre #(
    .MAX_TENTATIVAS (MAX_T),
    .TEMPO_BLOQUEIO (TEMPO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .chaves           (chaves),
    .btn_gravar       (btn_gravar),
    .btn_testar       (btn_testar),
    .igual            (igual),
    .senha            (senha),
    .tentativa        (tentativa),
    .tentativa_valida (tentativa_valida),
    .aberto           (aberto),
    .bloqueado        (bloqueado),
    .restantes        (restantes)
  );

  // The comparator this block drives in the real system.
  assign igual = (senha == tentativa);

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_tv     = 0;
  int n_bl     = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Behavioural model: what the safe must be doing, as a few flags.
  bit         m_tem_senha, m_aberto, m_avaliando, m_bloqueado;
  logic [3:0] m_senha, m_tent;
  int         m_rest, m_falta;
  bit   [2:0] hg, ht;
  bit         pg_m, pt_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tem_senha = 0; m_aberto = 0; m_avaliando = 0; m_bloqueado = 0;
      m_senha = '0; m_tent = '0; m_rest = MAX_T; m_falta = 0;
      hg = '0; ht = '0;
    end else begin
      // A press acts two edges after it was first sampled high.
      pg_m = hg[1] & ~hg[2];
      pt_m = ht[1] & ~ht[2];
      hg = {hg[1:0], btn_gravar};
      ht = {ht[1:0], btn_testar};
      if (m_avaliando) begin
        m_avaliando = 0;
        if (m_senha == m_tent) begin
          m_aberto = 1;
          m_rest   = MAX_T;
        end else if (m_rest > 1) begin
          m_rest--;
        end else begin
          m_rest      = 0;
          m_bloqueado = 1;
          m_falta     = TEMPO;
        end
      end else if (m_bloqueado) begin
        m_falta--;
        if (m_falta == 0) begin
          m_bloqueado = 0;
          m_rest      = MAX_T;
        end
      end else if (!m_tem_senha) begin
        if (pg_m) begin
          m_senha     = chaves;
          m_tem_senha = 1;
        end
      end else if (m_aberto) begin
        if (pg_m) m_senha = chaves;
        else if (pt_m) m_aberto = 0;
      end else if (pt_m) begin
        m_tent      = chaves;
        m_avaliando = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("senha", senha, m_senha);
    check("tentativa", tentativa, m_tent);
    check("tentativa_valida", tentativa_valida, m_avaliando);
    check("aberto", aberto, m_aberto);
    check("bloqueado", bloqueado, m_bloqueado);
    check("restantes", restantes, m_rest[2:0]);
    if (tentativa_valida) n_tv++;
    if (bloqueado) n_bl++;
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic aperta_gravar(input logic [3:0] v, input int hold);
    chaves = v; btn_gravar = 1'b1;
    ciclos(hold);
    btn_gravar = 1'b0;
  endtask

  task automatic aperta_testar(input logic [3:0] v, input int hold);
    chaves = v; btn_testar = 1'b1;
    ciclos(hold);
    btn_testar = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tv0, bl0, k;
    rst = 1'b1; chaves = '0; btn_gravar = 1'b0; btn_testar = 1'b0;
    ciclos(3);
    check("rst_senha", senha, 4'h0);
    check("rst_restantes", restantes, 3'd3);
    check("rst_flags", {aberto, bloqueado, tentativa_valida}, 3'b000);
    rst = 1'b0;
    ciclos(2);

    // 1: password capture lands on the third edge.
    chaves = 4'hA; btn_gravar = 1'b1;
    ciclos(2);
    check("t1_senha_2bordas", senha, 4'h0);
    ciclos(1);
    check("t1_senha_3bordas", senha, 4'hA);
    btn_gravar = 1'b0;
    ciclos(3);
    check("t1_restantes", restantes, 3'd3);
    check("t1_flags", {aberto, bloqueado}, 2'b00);

    // 2: correct attempt opens.
    tv0 = n_tv;
    aperta_testar(4'hA, 2); ciclos(4);
    check("t2_tentativa", tentativa, 4'hA);
    check("t2_valida_1ciclo", n_tv - tv0, 1);
    check("t2_aberto", aberto, 1'b1);
    check("t2_restantes", restantes, 3'd3);

    // 3: close, then three wrong attempts lock for TEMPO cycles.
    aperta_testar(4'hA, 2); ciclos(4);
    check("t3_fecha", aberto, 1'b0);
    aperta_testar(4'h7, 2); ciclos(4);
    check("t3_restantes_2", restantes, 3'd2);
    aperta_testar(4'h7, 2); ciclos(4);
    check("t3_restantes_1", restantes, 3'd1);
    bl0 = n_bl; tv0 = n_tv;
    aperta_testar(4'h7, 2); ciclos(2);
    check("t3_bloqueado", bloqueado, 1'b1);
    check("t3_restantes_0", restantes, 3'd0);
    aperta_testar(4'h2, 2); ciclos(12);
    check("t3_duracao", n_bl - bl0, TEMPO);
    check("t3_ignora_testar", n_tv - tv0, 1);
    check("t3_tentativa_mantida", tentativa, 4'h7);
    check("t3_desbloqueado", bloqueado, 1'b0);
    check("t3_restantes_rec", restantes, 3'd3);
    aperta_testar(4'hA, 2); ciclos(4);
    check("t3_armado_apos", aberto, 1'b1);

    // 4: change password while open.
    aperta_gravar(4'h3, 2); ciclos(4);
    check("t4_senha", senha, 4'h3);
    check("t4_aberto_mantido", aberto, 1'b1);
    aperta_testar(4'h3, 2); ciclos(4);
    check("t4_fecha", aberto, 1'b0);
    aperta_testar(4'h3, 2); ciclos(4);
    check("t4_reabre", aberto, 1'b1);

    // 5: a held button writes once; gravar beats a coincident testar.
    chaves = 4'h5; btn_gravar = 1'b1;
    ciclos(10);
    chaves = 4'h6;
    ciclos(10);
    btn_gravar = 1'b0;
    ciclos(4);
    check("t5_escrita_unica", senha, 4'h5);
    chaves = 4'h9; btn_gravar = 1'b1; btn_testar = 1'b1;
    ciclos(2);
    btn_gravar = 1'b0; btn_testar = 1'b0;
    ciclos(4);
    check("t5_simult_senha", senha, 4'h9);
    check("t5_simult_aberto", aberto, 1'b1);

    // 6: reset in the middle of a lockout.
    aperta_testar(4'h9, 2); ciclos(4);
    aperta_testar(4'h0, 2); ciclos(4);
    aperta_testar(4'h0, 2); ciclos(4);
    aperta_testar(4'h0, 2);
    k = 0;
    while (!bloqueado && k < 20) begin
      ciclos(1);
      k++;
    end
    check("t6_bloqueio_visto", bloqueado, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_bloqueado", bloqueado, 1'b0);
    check("t6_rst_senha", senha, 4'h0);
    check("t6_rst_tentativa", tentativa, 4'h0);
    check("t6_rst_restantes", restantes, 3'd3);
    @(negedge clk);
    ciclos(2);
    rst = 1'b0;
    ciclos(2);
    tv0 = n_tv;
    aperta_testar(4'hC, 2); ciclos(5);
    check("t6_testar_sem_senha", tentativa, 4'h0);
    check("t6_sem_valida", n_tv - tv0, 0);
    aperta_gravar(4'h5, 2); ciclos(4);
    check("t6_nova_senha", senha, 4'h5);
    aperta_testar(4'h5, 2); ciclos(4);
    check("t6_abre", aberto, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
